// File: rtl/cpu.sv
// Multi-cycle RV32I core: FETCH -> DECODE -> EXEC -> (WB for loads) -> FETCH.
// Memory is synchronous; read data arrives the cycle after re is sampled.

module cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] file1 [0:31];

    always_ff @(posedge clk)
        if (we && wa != 5'd0) file1[wa] <= wd;

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : file1[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : file1[ra2];
endmodule

module cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] addr,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic        re,
    output logic [3:0]  we,
    output logic        halt,
    output logic [31:0] pc
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                           OP_FENCE = 7'b0001111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALTED} state_t;
    state_t state;

    // Anything not accepted here (ECALL/EBREAK included) halts the core in EXEC.
    function automatic logic legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = (f3 == 3'd0);
            OP_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
            OP_LOAD:   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            OP_STORE:  legal = (f3 <= 3'd2);
            OP_IMM:    legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                               (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OP_OP:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OP_FENCE:  legal = (f3 == 3'd0);
            default:   legal = 1'b0;
        endcase
    endfunction

    logic [31:0] ir, rs1_q, rs2_q, rs1_v, rs2_v, addr_q;
    logic [1:0]  off_q;
    logic        re_q;

    // Decode-time view of the freshly fetched word (valid only in DECODE).
    logic        d_legal, d_load, d_store;
    logic [31:0] d_imm, d_maddr, d_wdata;
    logic [3:0]  d_we;

    always_comb begin
        d_legal = legal(rdata);
        d_load  = d_legal && rdata[6:0] == OP_LOAD;
        d_store = d_legal && rdata[6:0] == OP_STORE;
        d_imm   = d_store ? {{20{rdata[31]}}, rdata[31:25], rdata[11:7]}
                          : {{20{rdata[31]}}, rdata[31:20]};
        d_maddr = rs1_v + d_imm;
        case (rdata[13:12])
            2'd0:    begin d_we = 4'b0001 << d_maddr[1:0]; d_wdata = {4{rs2_v[7:0]}}; end
            2'd1:    begin d_we = d_maddr[1] ? 4'b1100 : 4'b0011; d_wdata = {2{rs2_v[15:0]}}; end
            default: begin d_we = 4'b1111; d_wdata = rs2_v; end
        endcase
    end

    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [31:0] imm_i, imm_u, imm_b, imm_j, alu_y, alu_out, e_res, e_npc, npc_al, ld_val;
    logic        alu_alt, e_legal, e_wr, taken;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign e_op  = ir[6:0];
    assign e_f3  = ir[14:12];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_u = {ir[31:12], 12'd0};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        alu_y   = (e_op == OP_OP) ? rs2_q : imm_i;
        alu_alt = (e_op == OP_OP) ? ir[30] : (e_f3 == 3'd5) && ir[30];
        case (e_f3)
            3'd0:    alu_out = alu_alt ? rs1_q - alu_y : rs1_q + alu_y;
            3'd1:    alu_out = rs1_q << alu_y[4:0];
            3'd2:    alu_out = {31'd0, $signed(rs1_q) < $signed(alu_y)};
            3'd3:    alu_out = {31'd0, rs1_q < alu_y};
            3'd4:    alu_out = rs1_q ^ alu_y;
            3'd5:    alu_out = alu_alt ? $unsigned($signed(rs1_q) >>> alu_y[4:0]) : rs1_q >> alu_y[4:0];
            3'd6:    alu_out = rs1_q | alu_y;
            default: alu_out = rs1_q & alu_y;
        endcase
        case (e_f3)
            3'd0:    taken = rs1_q == rs2_q;
            3'd1:    taken = rs1_q != rs2_q;
            3'd4:    taken = $signed(rs1_q) < $signed(rs2_q);
            3'd5:    taken = $signed(rs1_q) >= $signed(rs2_q);
            3'd6:    taken = rs1_q < rs2_q;
            3'd7:    taken = rs1_q >= rs2_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        e_legal = legal(ir);
        e_res   = alu_out;
        e_npc   = pc + 32'd4;
        e_wr    = 1'b0;
        case (e_op)
            OP_LUI:        begin e_res = imm_u; e_wr = 1'b1; end
            OP_AUIPC:      begin e_res = pc + imm_u; e_wr = 1'b1; end
            OP_JAL:        begin e_res = pc + 32'd4; e_wr = 1'b1; e_npc = pc + imm_j; end
            OP_JALR:       begin e_res = pc + 32'd4; e_wr = 1'b1; e_npc = (rs1_q + imm_i) & ~32'd1; end
            OP_BRANCH:     if (taken) e_npc = pc + imm_b;
            OP_IMM, OP_OP: e_wr = 1'b1;
            default:       ;
        endcase
        npc_al  = e_npc & ~32'd3;
        ld_byte = rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? rdata[31:16] : rdata[15:0];
        case (e_f3)
            3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_val = {24'd0, ld_byte};
            3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_val = {16'd0, ld_half};
            default: ld_val = rdata;
        endcase
    end

    cpu_regfile reg_file (
        .clk (clk),
        .ra1 (rdata[19:15]),
        .ra2 (rdata[24:20]),
        .rd1 (rs1_v),
        .rd2 (rs2_v),
        .we  ((state == EXEC && e_legal && e_wr) || state == WB),
        .wa  (ir[11:7]),
        .wd  ((state == WB) ? ld_val : e_res)
    );

    // re is pre-armed for the first fetch but masked while reset is held.
    assign re   = re_q & rst_n;
    assign addr = addr_q[31:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            halt   <= 1'b0;
            re_q   <= 1'b1;
            we     <= 4'd0;
            wdata  <= 32'd0;
            ir     <= 32'd0;
            rs1_q  <= 32'd0;
            rs2_q  <= 32'd0;
            off_q  <= 2'd0;
        end else begin
            case (state)
                FETCH: begin
                    re_q  <= 1'b0;
                    state <= DECODE;
                end
                DECODE: begin
                    ir    <= rdata;
                    rs1_q <= rs1_v;
                    rs2_q <= rs2_v;
                    off_q <= d_maddr[1:0];
                    state <= EXEC;
                    if (d_load) begin
                        re_q   <= 1'b1;
                        addr_q <= d_maddr;
                    end
                    if (d_store) begin
                        we     <= d_we;
                        wdata  <= d_wdata;
                        addr_q <= d_maddr;
                    end
                end
                EXEC: begin
                    we <= 4'd0;
                    if (!e_legal) begin
                        halt  <= 1'b1;
                        re_q  <= 1'b0;
                        state <= HALTED;
                    end else if (e_op == OP_LOAD) begin
                        re_q  <= 1'b0;
                        state <= WB;
                    end else begin
                        pc     <= npc_al;
                        addr_q <= npc_al;
                        re_q   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                WB: begin
                    pc     <= pc + 32'd4;
                    addr_q <= pc + 32'd4;
                    re_q   <= 1'b1;
                    state  <= FETCH;
                end
                default: begin
                    re_q <= 1'b0;
                    we   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed programs for the cpu core, run against a synchronous 2048x32 ram model.
// Each program ends in ECALL; registers and memory are compared with hand-computed values.

module tb_cpu;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011,
                           OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk, rst_n;
    logic [29:0] addr;
    logic [31:0] rdata, wdata, pc;
    logic        re, halt;
    logic [3:0]  we;

    cpu #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rdata(rdata), .wdata(wdata),
        .re(re), .we(we), .halt(halt), .pc(pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
    end

    // ram with a bench-only load port used while the core is in reset
    logic [31:0] mem [0:2047];
    logic        ld_en = 1'b0;
    logic [10:0] ld_addr;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else
            for (int n = 0; n < 4; n++)
                if (we[n]) mem[addr[10:0]][8*n +: 8] <= wdata[8*n +: 8];
        if (re) rdata <= mem[addr[10:0]];
    end

    // bus monitor
    int          overlap_cnt = 0;
    int          after_halt_cnt = 0;
    logic [3:0]  last_we = 4'd0;
    logic [31:0] last_wdata = 32'd0;

    always @(negedge clk) if (rst_n) begin
        if (re && we != 4'd0) overlap_cnt++;
        if (halt && (re || we != 4'd0)) after_halt_cnt++;
        if (we != 4'd0) begin
            last_we    = we;
            last_wdata = wdata;
        end
    end

    // scoreboard
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // instruction encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_OP};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // driver tasks
    logic [31:0] prog[$];

    task automatic mem_load(input int a, input logic [31:0] d);
        ld_addr = a[10:0];
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic load_prog();
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++)
            mem_load(i, (i < prog.size()) ? prog[i] : 32'd0);
    endtask

    task automatic run_prog(input int max_cyc, output int cyc);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!halt && cyc < max_cyc) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("halt_reached", {31'd0, halt}, 32'd1);
    endtask

    function automatic logic [31:0] xr(input int n);
        return dut.reg_file.file1[n];
    endfunction

    int cyc;
    bit found;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_re", {31'd0, re}, 32'd0);
        check("rst_we", {28'd0, we}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_wdata", wdata, 32'd0);

        // ADDI / ADDI / ADD / ECALL
        prog = {enc_i(5, 0, 0, 1, OP_IMM), enc_i(-3, 0, 0, 2, OP_IMM),
                enc_r(7'h00, 2, 1, 0, 3), ECALL};
        load_prog();
        run_prog(50, cyc);
        check("p1_x3", xr(3), 32'd2);
        check("p1_x2", xr(2), 32'hFFFF_FFFD);
        check("p1_pc", pc, 32'd12);
        check("p1_cycles", cyc, 32'd12);

        // store then byte/half/word loads
        prog = {enc_i(32'h80818, 0, 0, 5, OP_LUI) | 32'h0,
                enc_i(32'h2F3, 5, 0, 5, OP_IMM), enc_i(32'h100, 0, 0, 6, OP_IMM),
                enc_s(0, 5, 6, 2), enc_i(0, 6, 0, 7, OP_LOAD), enc_i(0, 6, 4, 8, OP_LOAD),
                enc_i(2, 6, 1, 9, OP_LOAD), enc_s(1, 5, 6, 0), enc_i(0, 6, 2, 10, OP_LOAD), ECALL};
        prog[0] = {20'h80818, 5'd5, OP_LUI};
        load_prog();
        run_prog(200, cyc);
        check("p2_lb", xr(7), 32'hFFFF_FFF3);
        check("p2_lbu", xr(8), 32'h0000_00F3);
        check("p2_lh", xr(9), 32'hFFFF_8081);
        check("p2_sb_we", {28'd0, last_we}, 32'h2);
        check("p2_sb_wdata", last_wdata, 32'hF3F3_F3F3);
        check("p2_lw", xr(10), 32'h8081_F3F3);
        check("p2_mem", mem[64], 32'h8081_F3F3);

        // branches and jumps
        prog = {enc_i(3, 0, 0, 1, OP_IMM), enc_i(3, 0, 0, 2, OP_IMM), enc_b(8, 2, 1, 0),
                enc_i(32'haa, 0, 0, 31, OP_IMM), enc_i(32'h55, 0, 0, 31, OP_IMM),
                enc_b(8, 2, 1, 1), enc_i(7, 0, 0, 4, OP_IMM), enc_i(9, 0, 0, 0, OP_IMM),
                enc_j(8, 1), enc_i(32'haa, 0, 0, 31, OP_IMM), enc_i(1, 0, 0, 11, OP_IMM),
                enc_i(53, 0, 0, 12, OP_JALR), enc_i(32'haa, 0, 0, 31, OP_IMM), ECALL};
        load_prog();
        run_prog(200, cyc);
        check("p3_jal_link", xr(1), 32'h24);
        check("p3_x31_pass", xr(31), 32'h55);
        check("p3_bne_fall", xr(4), 32'd7);
        check("p3_jal_target", xr(11), 32'd1);
        check("p3_x0_discard", {31'd0, dut.reg_file.file1[0] === 32'd9}, 32'd0);
        check("p3_jalr_link", xr(12), 32'd48);
        check("p3_pc", pc, 32'd52);

        // shifts and compares
        prog = {32'h0, enc_i(32'h404, 1, 5, 2, OP_IMM), enc_i(33, 0, 0, 3, OP_IMM),
                enc_r(7'h00, 3, 1, 5, 5), enc_i(1, 0, 0, 6, OP_IMM), enc_i(-1, 0, 0, 7, OP_IMM),
                enc_r(7'h00, 7, 6, 3, 8), enc_r(7'h00, 7, 6, 2, 9), enc_r(7'h20, 7, 6, 0, 10),
                enc_r(7'h00, 3, 6, 1, 11), enc_i(0, 7, 2, 12, OP_IMM), enc_i(-1, 6, 3, 13, OP_IMM),
                enc_i(32'hF0, 7, 4, 14, OP_IMM), enc_r(7'h20, 3, 1, 5, 15), ECALL};
        prog[0] = {20'h80000, 5'd1, OP_LUI};
        load_prog();
        run_prog(300, cyc);
        check("p4_srai", xr(2), 32'hF800_0000);
        check("p4_srl33", xr(5), 32'h4000_0000);
        check("p4_sltu", xr(8), 32'd1);
        check("p4_slt", xr(9), 32'd0);
        check("p4_sub", xr(10), 32'd2);
        check("p4_sll33", xr(11), 32'd2);
        check("p4_slti", xr(12), 32'd1);
        check("p4_sltiu", xr(13), 32'd1);
        check("p4_xori", xr(14), 32'hFFFF_FF0F);
        check("p4_sra33", xr(15), 32'hC000_0000);

        // reset during the EXEC cycle of a store
        prog = {enc_i(32'h100, 0, 0, 6, OP_IMM), enc_i(32'h77, 0, 0, 5, OP_IMM),
                enc_s(0, 5, 6, 2), ECALL};
        load_prog();
        mem_load(64, 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (we != 4'd0) found = 1'b1;
        end
        check("p5_store_we", {28'd0, we}, 32'hF);
        rst_n = 1'b0;
        #1;
        check("p5_rst_we", {28'd0, we}, 32'd0);
        check("p5_rst_re", {31'd0, re}, 32'd0);
        check("p5_rst_pc", pc, 32'h0);
        check("p5_rst_halt", {31'd0, halt}, 32'd0);
        @(posedge clk);
        #1 check("p5_mem_kept", mem[64], 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("p5_refetch_re", {31'd0, re}, 32'd1);
        check("p5_refetch_addr", {2'd0, addr}, 32'd0);
        cyc = 0;
        while (!halt && cyc < 60) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("p5_halt", {31'd0, halt}, 32'd1);
        check("p5_mem_rerun", mem[64], 32'h77);
        check("p5_pc", pc, 32'd12);

        // illegal all-zero word
        prog = {enc_i(1, 0, 0, 1, OP_IMM), 32'h0};
        load_prog();
        after_halt_cnt = 0;
        run_prog(50, cyc);
        check("p6_cycles", cyc, 32'd6);
        check("p6_pc", pc, 32'd4);
        check("p6_x1", xr(1), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("p6_halt_sticky", {31'd0, halt}, 32'd1);
        check("p6_pc_frozen", pc, 32'd4);
        check("p6_no_bus_after_halt", after_halt_cnt, 32'd0);

        check("re_we_overlap", overlap_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the byte address of the first instruction fetched after reset.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, on ports clk and rst_n.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port addr  output  30  word address to memory, equal to byte address [31:2].
REQ-006 Port rdata  input  32  memory read data, valid the cycle after re is sampled high.
REQ-007 Port wdata  output  32  store data, replicated across byte lanes (SB: byte×4, SH: half×2).
REQ-008 Port re  output  1  read strobe for instruction fetch or load.
REQ-009 Port we  output  4  per-byte write enables; bit n writes lane [8n+7:8n].
REQ-010 Port halt  output  1  high once the core has stopped; sticky until reset.
REQ-011 Port pc  output  32  current program counter, byte address.
REQ-012 The register file SHALL be a submodule instance named reg_file with storage array file1[0:31] of 32 bits, so that x28 and x31 are probeable hierarchically.

Function
REQ-013 The block SHALL execute RV32I user instructions: LUI, AUIPC, JAL, JALR, all branches, all loads/stores, OP-IMM, OP, and FENCE, which executes as a no-op.
REQ-014 ECALL, EBREAK and any unrecognised encoding SHALL set halt; pc then freezes on that instruction, and re and we stay 0.
REQ-015 Control SHALL be a multi-cycle FSM: FETCH -> DECODE -> EXEC -> (WB for loads only) -> FETCH.
REQ-016 FETCH: re=1, addr=pc[31:2], we=0.
REQ-017 DECODE: latch rdata as the instruction and read rs1 and rs2.
REQ-018 EXEC for ALU, branch and jump instructions: write rd, update pc, then go to FETCH; these take 3 cycles per instruction.
REQ-019 EXEC for a store: drive addr, wdata and we for exactly one cycle, update pc, then go to FETCH (3 cycles).
REQ-020 EXEC for a load: drive re=1 and addr, then go to WB.
REQ-021 WB for a load: select lane(s) from rdata by byte offset, sign- or zero-extend, write rd, pc+=4 (4 cycles per load).
REQ-022 Writes to x0 SHALL be discarded, and x0 SHALL always read 0.
REQ-023 Arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-024 Shift amounts SHALL be the low 5 bits of the operand; SRA and SRAI SHALL be arithmetic shifts.
REQ-025 SLT and SLTI compare signed; SLTU and SLTIU compare unsigned.
REQ-026 Branch and jump targets SHALL be pc+imm; JALR uses (rs1+imm) with bit 0 cleared.
REQ-027 JAL and JALR SHALL write pc+4 to rd.
REQ-028 Alignment: bits [1:0] of any pc target SHALL be forced to 0.
REQ-029 Halfword accesses SHALL use byte-offset bit 1 only; word accesses SHALL ignore the byte offset; no misalignment traps are raised.
REQ-030 re and any we bit SHALL never be asserted in the same cycle.
REQ-031 re SHALL be 0 in DECODE.
REQ-032 Test convention, which the core does not enforce: software writes x31=0x55 for pass and 0xaa for fail, then executes ECALL.

Reset
REQ-033 While rst_n=0: pc=RESET_PC, FSM=FETCH, halt=0, re=0, we=0, wdata=0.
REQ-034 Register file contents (except x0) SHALL NOT be reset.
REQ-035 Reset asserted mid-instruction SHALL abort that instruction with no partial register write.
REQ-036 The first fetch SHALL occur in the first clock after rst_n deasserts.

Companion memory (ram, bench-side)
REQ-037 ram SHALL be synchronous, 2048×32, word-addressed by addr[10:0], with dout registered on re and a byte-masked write on we, both at posedge clk.

Verification
REQ-038 Sequence ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; ECALL from 0 -> x3=2, halt=1, pc=12, 12 cycles to halt.
REQ-039 Store then load: SW of 0x8081_82F3 at 0x100, then LB/LBU at offset 0 and LH at offset 2 -> 0xFFFF_FFF3, 0x0000_00F3, 0xFFFF_8081; SB at 0x101 -> we=4'b0010.
REQ-040 Branch and jump: BEQ taken to +8 skipping ADDI x31,x0,0xaa; JAL x1,+8 from pc 0x20 -> x1=0x24, pc=0x28; final x31=0x55 (pass).
REQ-041 Shifts and compares: SRAI of 0x8000_0000 by 4 -> 0xF800_0000; SRL by register value 33 -> shift by 1; SLTU 1 < 0xFFFF_FFFF -> 1; SLT -> 0.
REQ-042 Reset mid-run: pull rst_n low during EXEC of a store -> we=0 immediately, memory unchanged, pc=RESET_PC, halt=0; restart re-fetches from RESET_PC.
REQ-043 Illegal opcode 0x0000_0000 -> halt=1 within 3 cycles, with pc pointing at that word and no further re or we.
